// File: rtl/seven_segment_capture.sv
// Scrapes a time-multiplexed 4-digit seven-segment bus back into BCD.
// Each digit pattern must be seen STABLE_CYCLES times in a row before it is captured.
module seven_segment_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_blank,
  output logic        frame_valid,
  output logic        err,
  output logic [6:0]  err_pattern
);

  localparam int NUM_DIGITS = 4;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HELD   = 2'd2;
  localparam logic [7:0] STB    = 8'(STABLE_CYCLES);

  logic [6:0] seg_q, last_seg;
  logic [3:0] sel_q, last_sel;
  logic [1:0] state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       sel_ok, same, cap;
  logic [3:0] dec_val;
  logic       dec_ok, dec_blank;
  logic [3:0] seen, seen_or;
  logic [NUM_DIGITS-1:0][3:0] dig_r;

  // last_* holds the sample the FSM evaluated on the previous edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '0;
      sel_q    <= '0;
      last_seg <= '0;
      last_sel <= '0;
    end else begin
      seg_q    <= seg;
      sel_q    <= dig_sel;
      last_seg <= seg_q;
      last_sel <= sel_q;
    end
  end

  assign sel_ok = $onehot(sel_q);
  assign same   = (seg_q == last_seg) && (sel_q == last_sel);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    if (!sel_ok) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (!(state == HELD && same)) begin
      // cnt counts the current sample, so STABLE_CYCLES=1 captures at once
      if (state == SETTLE && same) cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
      else                         cnt_n = 8'd1;
      cap     = (cnt_n == STB);
      state_n = cap ? HELD : SETTLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    dec_val   = 4'd0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (seg_q)
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      7'h00: begin dec_ok = 1'b0; dec_blank = 1'b1; end
      default: dec_ok = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dig_r[i]       <= '0;
        digit_valid[i] <= 1'b0;
        digit_blank[i] <= 1'b0;
      end else if (cap && sel_q[i]) begin
        if (dec_ok) dig_r[i] <= dec_val;
        digit_valid[i] <= dec_ok;
        digit_blank[i] <= dec_blank;
      end
    end
  end

  assign digits  = dig_r;
  assign seen_or = seen | (cap ? sel_q : 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_pattern <= '0;
    end else begin
      frame_valid <= (seen_or == 4'hF);
      seen        <= (seen_or == 4'hF) ? 4'h0 : seen_or;
      err         <= cap && !dec_ok && !dec_blank;
      if (cap && !dec_ok && !dec_blank) err_pattern <= seg_q;
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Random and directed checks of two capture instances (STABLE_CYCLES 4 and 1)
// against a run-length model of the segment bus.
module tb_seven_segment_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = '0;
  logic [3:0] dig_sel = '0;

  logic [15:0] o_dig[2];
  logic [3:0]  o_val[2], o_blk[2];
  logic        o_frm[2], o_err[2];
  logic [6:0]  o_ep[2];

  int checks = 0;
  int errors = 0;

  seven_segment_capture #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
    .digits(o_dig[0]), .digit_valid(o_val[0]), .digit_blank(o_blk[0]),
    .frame_valid(o_frm[0]), .err(o_err[0]), .err_pattern(o_ep[0]));

  seven_segment_capture #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
    .digits(o_dig[1]), .digit_valid(o_val[1]), .digit_blank(o_blk[1]),
    .frame_valid(o_frm[1]), .err(o_err[1]), .err_pattern(o_ep[1]));

  always #5 clk = ~clk;

  localparam logic [6:0] PAT[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                     7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int SC[2] = '{4, 1};

  // 0..9 numeral, 10 blank, 11 illegal
  function automatic int dec(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (s == PAT[k]) return k;
    return (s == 7'h00) ? 10 : 11;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a capture happens when a run of identical legal-select samples reaches length S
  logic [6:0]  m_seg[2], p_seg[2], m_ep[2];
  logic [3:0]  m_sel[2], p_sel[2], m_val[2], m_blk[2], m_seen[2];
  logic [15:0] m_dig[2];
  logic        m_frm[2], m_err[2];
  int          run[2];
  int          frm_cnt[2], err_cnt[2];

  always @(posedge clk or negedge rst_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_seg[m] = '0; m_sel[m] = '0; p_seg[m] = '0; p_sel[m] = '0;
        m_dig[m] = '0; m_val[m] = '0; m_blk[m] = '0; m_seen[m] = '0;
        m_frm[m] = 1'b0; m_err[m] = 1'b0; m_ep[m] = '0; run[m] = 0;
      end else begin
        m_frm[m] = 1'b0;
        m_err[m] = 1'b0;
        if ($onehot(m_sel[m]))
          run[m] = (m_seg[m] == p_seg[m] && m_sel[m] == p_sel[m]) ? run[m] + 1 : 1;
        else
          run[m] = 0;
        p_seg[m] = m_seg[m];
        p_sel[m] = m_sel[m];
        if (run[m] == SC[m]) begin
          int idx, d;
          idx = 0;
          for (int b = 0; b < 4; b++) if (m_sel[m][b]) idx = b;
          d = dec(m_seg[m]);
          if (d < 10) begin
            m_dig[m][idx*4 +: 4] = 4'(d);
            m_val[m][idx] = 1'b1;
            m_blk[m][idx] = 1'b0;
          end else begin
            m_val[m][idx] = 1'b0;
            m_blk[m][idx] = (d == 10);
            if (d == 11) begin
              m_err[m] = 1'b1;
              m_ep[m]  = m_seg[m];
            end
          end
          m_seen[m][idx] = 1'b1;
          if (m_seen[m] == 4'hF) begin
            m_frm[m]  = 1'b1;
            m_seen[m] = '0;
          end
        end
        m_seg[m] = seg;
        m_sel[m] = dig_sel;
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      string p;
      p = (m == 0) ? "s4" : "s1";
      chk({p, ".digits"},      32'(o_dig[m]), 32'(m_dig[m]));
      chk({p, ".digit_valid"}, 32'(o_val[m]), 32'(m_val[m]));
      chk({p, ".digit_blank"}, 32'(o_blk[m]), 32'(m_blk[m]));
      chk({p, ".frame_valid"}, 32'(o_frm[m]), 32'(m_frm[m]));
      chk({p, ".err"},         32'(o_err[m]), 32'(m_err[m]));
      chk({p, ".err_pattern"}, 32'(o_ep[m]),  32'(m_ep[m]));
      if (o_frm[m]) frm_cnt[m]++;
      if (o_err[m]) err_cnt[m]++;
    end
  end

  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    dig_sel = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst.digits", 32'(o_dig[m]), 32'h0);
      chk("rst.valid",  32'(o_val[m]), 32'h0);
      chk("rst.blank",  32'(o_blk[m]), 32'h0);
      chk("rst.frame",  32'(o_frm[m]), 32'h0);
      chk("rst.err",    32'(o_err[m]), 32'h0);
      chk("rst.errpat", 32'(o_ep[m]),  32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int f0, e0, f1;
    frm_cnt = '{0, 0};
    err_cnt = '{0, 0};
    repeat (3) @(negedge clk);
    chk("reset.digits", 32'(o_dig[0]), 32'h0);
    chk("reset.valid",  32'(o_val[0]), 32'h0);
    rst_n = 1'b1;

    // full frame
    f0 = frm_cnt[0];
    drive(7'h06, 4'b0001, 6);
    drive(7'h5B, 4'b0010, 6);
    drive(7'h66, 4'b0100, 6);
    drive(7'h7F, 4'b1000, 6);
    chk("frame.digits", 32'(o_dig[0]), 32'h8421);
    chk("frame.valid",  32'(o_val[0]), 32'hF);
    chk("frame.pulses", 32'(frm_cnt[0] - f0), 32'd1);

    // glitch: only the final run of 0x6D is long enough
    drive(7'h6D, 4'b0100, 3);
    drive(7'h7D, 4'b0100, 1);
    drive(7'h6D, 4'b0100, 4);
    drive(7'h00, 4'b0000, 2);
    chk("glitch.digit2", 32'(o_dig[0][11:8]), 32'd5);

    // illegal then blank on digit 1
    e0 = err_cnt[0];
    drive(7'h49, 4'b0010, 6);
    chk("illegal.errcnt", 32'(err_cnt[0] - e0), 32'd1);
    chk("illegal.errpat", 32'(o_ep[0]), 32'h49);
    chk("illegal.valid1", 32'(o_val[0][1]), 32'd0);
    chk("illegal.digit1", 32'(o_dig[0][7:4]), 32'd2);
    drive(7'h00, 4'b0010, 6);
    chk("blank.blank1", 32'(o_blk[0][1]), 32'd1);
    chk("blank.errcnt", 32'(err_cnt[0] - e0), 32'd1);

    // select faults
    e0 = err_cnt[0];
    f0 = frm_cnt[0];
    drive(7'h3F, 4'b0011, 20);
    drive(7'h3F, 4'b0000, 20);
    chk("selfault.err",   32'(err_cnt[0] - e0), 32'd0);
    chk("selfault.frame", 32'(frm_cnt[0] - f0), 32'd0);

    // one digit per cycle with STABLE_CYCLES=1: two frames from eight captures
    pulse_reset();
    f1 = frm_cnt[1];
    for (int k = 0; k < 8; k++) drive(PAT[k], 4'(1 << (k % 4)), 1);
    drive(7'h00, 4'b0000, 3);
    chk("s1.frames", 32'(frm_cnt[1] - f1), 32'd2);
    chk("s1.digits", 32'(o_dig[1]), 32'h7654);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      logic [6:0] s;
      logic [3:0] d;
      case ($urandom_range(0, 3))
        0, 1: s = PAT[$urandom_range(0, 9)];
        2:    s = 7'h00;
        default: s = 7'($urandom);
      endcase
      if ($urandom_range(0, 9) < 8) d = 4'(1 << $urandom_range(0, 3));
      else d = 4'($urandom);
      drive(s, d, $urandom_range(1, 7));
    end

    // reset in the middle of settling
    drive(7'h4F, 4'b0001, 2);
    pulse_reset();
    repeat (4) @(negedge clk);
    chk("postrst.early", 32'(o_val[0][0]), 32'd0);
    @(negedge clk);
    chk("postrst.digit0", 32'(o_dig[0][3:0]), 32'd3);
    chk("postrst.valid0", 32'(o_val[0][0]), 32'd1);
    drive(7'h00, 4'b0000, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
